// File: rtl/react_pkg.sv
// Shared definitions for the reaction-timer controller: sequencer codes,
// controller states and the LFSR constants.
package react_pkg;

  typedef enum logic [2:0] {
    MS_IDLE     = 3'd0,
    MS_WAIT     = 3'd1,
    MS_CLR_CNT1 = 3'd2,
    MS_START    = 3'd3,
    MS_STORAGE  = 3'd4,
    MS_CLR_CNT2 = 3'd5,
    MS_AVERAGE  = 3'd6,
    MS_COMPARE  = 3'd7
  } machine_state_t;

  typedef enum logic [2:0] {
    C_IDLE   = 3'd0,
    C_DELAY  = 3'd1,
    C_CLEAR  = 3'd2,
    C_TIMING = 3'd3,
    C_DONE   = 3'd4
  } ctrl_state_t;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; exposes its low OUT_W bits as the random value.
module lfsr16
  import react_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [OUT_W-1:0] rnd
);

  logic [15:0] state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LFSR_SEED;
    end else begin
      state <= lfsr_next(state);
    end
  end

  assign rnd = state[OUT_W-1:0];

endmodule

// File: rtl/react_timer_ctrl.sv
// Reaction-timer controller: random pre-start delay, millisecond reaction
// timing with saturation, and clear handling driven by the test sequencer.
module react_timer_ctrl
  import react_pkg::*;
#(
  parameter int CLK_PER_MS   = 50000,
  parameter int DELAY_MIN_MS = 1000,
  parameter int MAX_MS       = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] machine_state,
  output logic       signal_start,
  output logic       signal_overflow,
  output logic       signal_cleared,
  output logic [9:0] react_time,
  output logic       go_led
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_TERM  = PW'(CLK_PER_MS - 1);
  localparam logic [9:0]    MAX_T     = 10'(MAX_MS);
  localparam logic [11:0]   DELAY_MIN = 12'(DELAY_MIN_MS);

  machine_state_t ms;
  machine_state_t done_tag;
  ctrl_state_t    state;
  logic [PW-1:0]  prescaler;
  logic           ms_tick;
  logic [11:0]    delay_cnt;
  logic [10:0]    rnd;

  assign ms      = machine_state_t'(machine_state);
  assign ms_tick = (prescaler == PRE_TERM);

  lfsr16 #(.OUT_W(11)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .rnd (rnd)
  );

  // Leaving the current activity always wins over a same-cycle tick, so the
  // exit checks come before any tick handling in DELAY and TIMING.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= C_IDLE;
      done_tag        <= MS_IDLE;
      prescaler       <= '0;
      delay_cnt       <= '0;
      react_time      <= '0;
      signal_start    <= 1'b0;
      signal_overflow <= 1'b0;
      signal_cleared  <= 1'b0;
      go_led          <= 1'b0;
    end else begin
      signal_start    <= 1'b0;
      signal_overflow <= 1'b0;
      signal_cleared  <= 1'b0;
      prescaler       <= ms_tick ? '0 : prescaler + PW'(1);

      if (ms == MS_IDLE) begin
        state      <= C_IDLE;
        react_time <= '0;
        go_led     <= 1'b0;
      end else begin
        case (state)
          C_IDLE: begin
            case (ms)
              MS_WAIT: begin
                state     <= C_DELAY;
                delay_cnt <= DELAY_MIN + {1'b0, rnd};
                prescaler <= '0;
              end
              MS_START: begin
                state     <= C_TIMING;
                go_led    <= 1'b1;
                prescaler <= '0;
              end
              MS_CLR_CNT1, MS_CLR_CNT2: begin
                state          <= C_CLEAR;
                done_tag       <= ms;
                react_time     <= '0;
                signal_cleared <= 1'b1;
              end
              default: state <= C_IDLE;
            endcase
          end

          C_DELAY: begin
            if (ms != MS_WAIT) begin
              state <= C_IDLE;
            end else if (ms_tick) begin
              if (delay_cnt == 12'd1) begin
                signal_start <= 1'b1;
                state        <= C_DONE;
                done_tag     <= MS_WAIT;
                delay_cnt    <= '0;
              end else begin
                delay_cnt <= delay_cnt - 12'd1;
              end
            end
          end

          C_CLEAR: state <= C_DONE;

          C_TIMING: begin
            if (ms != MS_START) begin
              state  <= C_IDLE;
              go_led <= 1'b0;
            end else if (ms_tick) begin
              if (react_time >= MAX_T - 10'd1) begin
                react_time      <= MAX_T;
                signal_overflow <= 1'b1;
                state           <= C_DONE;
                done_tag        <= MS_START;
                go_led          <= 1'b0;
              end else begin
                react_time <= react_time + 10'd1;
              end
            end
          end

          C_DONE: begin
            if (ms != done_tag) state <= C_IDLE;
          end

          default: state <= C_IDLE;
        endcase
      end
    end
  end

endmodule
